traffic_light_param: RTL and testbench

Parametrised multi-approach traffic light controller for an intersection with `NUM_DIR` approaches. It is the successor to the fixed four-way controller and adds configurable phase durations and an arbitrary approach count. An optional compile-time feature adds demand-driven approach skipping and green rest. The block sits between the per-approach vehicle detectors and the lamp drivers.

---
 rtl/traffic_light_param.sv | 114 +++++++++++
 tb/tb_traffic_light_param.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_param.sv
// traffic_light_param: round-robin traffic light controller for NUM_DIR approaches.
// Define SENSOR_SKIP_EN to enable demand-driven approach skipping and green rest.
module traffic_light_param #(
    parameter int NUM_DIR    = 4,
    parameter int CNT_W      = 16,
    parameter int GREEN_CYC  = 20,
    parameter int YELLOW_CYC = 5,
    parameter int ALLRED_CYC = 2,
    localparam int DIR_W     = $clog2(NUM_DIR)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_DIR-1:0]   sensor,
    output logic [3*NUM_DIR-1:0] lights,
    output logic [DIR_W-1:0]     active_dir,
    output logic [1:0]           phase
);

    typedef enum logic [1:0] {
        ALL_RED = 2'd0,
        GREEN   = 2'd1,
        YELLOW  = 2'd2
    } state_t;

    state_t           state;
    logic             run;
    logic [CNT_W-1:0] cnt;
    logic [DIR_W-1:0] nxt_dir;
    logic             go;
    logic             leave_green;

    function automatic logic [3*NUM_DIR-1:0] lamp(input state_t s, input logic [DIR_W-1:0] d);
        logic [3*NUM_DIR-1:0] l;
        for (int unsigned i = 0; i < NUM_DIR; i++) begin
            if (s == GREEN && i == 32'(d))
                l[3*i +: 3] = 3'b001;
            else if (s == YELLOW && i == 32'(d))
                l[3*i +: 3] = 3'b010;
            else
                l[3*i +: 3] = 3'b100;
        end
        return l;
    endfunction

`ifdef SENSOR_SKIP_EN
    int unsigned idx;

    // First demanding approach after the current one, ending with the current one itself.
    always_comb begin
        go      = 1'b0;
        nxt_dir = active_dir;
        idx     = 0;
        for (int unsigned k = 1; k <= NUM_DIR; k++) begin
            idx = (32'(active_dir) + k) % NUM_DIR;
            if (!go && sensor[idx]) begin
                go      = 1'b1;
                nxt_dir = DIR_W'(idx);
            end
        end
    end

    assign leave_green = |(sensor & ~(NUM_DIR'(1) << active_dir));
`else
    logic sensor_unused;

    assign sensor_unused = ^sensor;
    assign go            = 1'b1;
    assign leave_green   = 1'b1;
    assign nxt_dir       = (active_dir == DIR_W'(NUM_DIR - 1)) ? '0 : active_dir + 1'b1;
`endif

    assign phase = state;

    // run releases one edge after reset; the counter may reach 1 meanwhile but holds there.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run        <= 1'b0;
            state      <= ALL_RED;
            cnt        <= CNT_W'(ALLRED_CYC);
            active_dir <= DIR_W'(NUM_DIR - 1);
            lights     <= lamp(ALL_RED, '0);
        end else begin
            run <= 1'b1;
            if (cnt != CNT_W'(1)) begin
                cnt <= cnt - 1'b1;
            end else if (run) begin
                case (state)
                    ALL_RED: if (go) begin
                        state      <= GREEN;
                        cnt        <= CNT_W'(GREEN_CYC);
                        active_dir <= nxt_dir;
                        lights     <= lamp(GREEN, nxt_dir);
                    end
                    GREEN: if (leave_green) begin
                        state  <= YELLOW;
                        cnt    <= CNT_W'(YELLOW_CYC);
                        lights <= lamp(YELLOW, active_dir);
                    end
                    YELLOW: begin
                        state  <= ALL_RED;
                        cnt    <= CNT_W'(ALLRED_CYC);
                        lights <= lamp(ALL_RED, active_dir);
                    end
                    default: begin
                        state  <= ALL_RED;
                        cnt    <= CNT_W'(ALLRED_CYC);
                        lights <= lamp(ALL_RED, active_dir);
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_traffic_light_param.sv
// Bench for traffic_light_param: timeline model of the fixed rotation plus directed
// scenarios (reset mid-phase, 3-approach wrap, and SENSOR_SKIP_EN demand behaviour).
module tb_traffic_light_param;

    localparam int N = 4, G = 20, Y = 5, R = 2;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic [3:0]  sen_a;
    logic [2:0]  sen_b = '1;
    logic [11:0] lights_a;
    logic [1:0]  dir_a, phase_a;
    logic [8:0]  lights_b;
    logic [1:0]  dir_b, phase_b;

    int total  = 0;
    int passed = 0;
    int ta     = 0;
    int tb3    = 0;

    traffic_light_param #(
        .NUM_DIR(N), .CNT_W(16), .GREEN_CYC(G), .YELLOW_CYC(Y), .ALLRED_CYC(R)
    ) dut (
        .clk(clk), .reset(rst_a), .sensor(sen_a),
        .lights(lights_a), .active_dir(dir_a), .phase(phase_a)
    );

    // All approaches always demanding makes the skip build behave as plain rotation.
    traffic_light_param #(
        .NUM_DIR(3), .CNT_W(8), .GREEN_CYC(1), .YELLOW_CYC(1), .ALLRED_CYC(1)
    ) dut3 (
        .clk(clk), .reset(rst_b), .sensor(sen_b),
        .lights(lights_b), .active_dir(dir_b), .phase(phase_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_a)
        if (!rst_a) ta <= 0; else ta <= ta + 1;

    always @(posedge clk or negedge rst_b)
        if (!rst_b) tb3 <= 0; else tb3 <= tb3 + 1;

    // Phase/approach after t edges since release in a fixed rotation.
    function automatic void model(input int n, input int g, input int y, input int r,
                                  input int t, output int ph, output int d);
        int a0, u, p, rr;
        a0 = (r > 2) ? r : 2;
        p  = g + y + r;
        if (t < a0) begin
            ph = 0;
            d  = n - 1;
        end else begin
            u  = t - a0;
            rr = u % p;
            d  = (u / p) % n;
            ph = (rr < g) ? 1 : (rr < g + y) ? 2 : 0;
        end
    endfunction

    function automatic logic [11:0] lamps(input int n, input int ph, input int d);
        logic [11:0] l;
        l = '0;
        for (int i = 0; i < n; i++) l[3*i +: 3] = 3'b100;
        if (ph == 1) l[3*d +: 3] = 3'b001;
        else if (ph == 2) l[3*d +: 3] = 3'b010;
        return l;
    endfunction

    function automatic bit safe(input logic [11:0] l, input int n);
        int lit;
        bit ok;
        logic [2:0] f;
        lit = 0;
        ok  = 1'b1;
        for (int i = 0; i < n; i++) begin
            f = l[3*i +: 3];
            if (f != 3'b100) lit++;
            if (f != 3'b100 && f != 3'b010 && f != 3'b001) ok = 1'b0;
        end
        return ok && lit <= 1;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    always @(negedge clk) begin
        int ph, d;
        logic [11:0] lb;
`ifndef SENSOR_SKIP_EN
        model(N, G, Y, R, ta, ph, d);
        check("model_a", {lights_a, phase_a, dir_a}, {lamps(N, ph, d), 2'(ph), 2'(d)});
`endif
        check("safety_a", 32'(safe(lights_a, N)), 32'd1);
        model(3, 1, 1, 1, tb3, ph, d);
        lb = lamps(3, ph, d);
        check("model_b", {lights_b, phase_b, dir_b}, {lb[8:0], 2'(ph), 2'(d)});
        check("safety_b", 32'(safe({3'b000, lights_b}, 3)), 32'd1);
    end

    task automatic at(input int n);
        int budget;
        budget = 0;
        while (ta < n && budget < 5000) begin
            @(negedge clk);
            budget++;
        end
        if (ta != n) begin
            total++;
            $display("FAIL wait_edge_%0d: reached %0d required %0d", n, ta, n);
        end
    endtask

    task automatic lit_a(input string nm, input logic [11:0] l, input logic [1:0] p,
                         input logic [1:0] d);
        check(nm, {lights_a, phase_a, dir_a}, {l, p, d});
    endtask

    task automatic pins_b();
        at(8);
        check("b_green2", {lights_b, phase_b, dir_b}, {9'h064, 2'd1, 2'd2});
        at(10);
        check("b_allred2", {lights_b, phase_b, dir_b}, {9'h124, 2'd0, 2'd2});
        at(11);
        check("b_wrap0", {lights_b, phase_b, dir_b}, {9'h121, 2'd1, 2'd0});
    endtask

    task automatic release_a();
        @(negedge clk);
        @(negedge clk);
        rst_a = 1'b1;
    endtask

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
`ifdef SENSOR_SKIP_EN
        sen_a = 4'b0100;
`else
        sen_a = 4'b0000;
`endif
        repeat (3) @(negedge clk);
        rst_a = 1'b1;
        rst_b = 1'b1;
`ifndef SENSOR_SKIP_EN
        at(1);   lit_a("edge1_allred", 12'h924, 2'd0, 2'd3);
        at(2);   lit_a("first_green0", 12'h921, 2'd1, 2'd0);
        pins_b();
        at(22);  lit_a("yellow0",      12'h922, 2'd2, 2'd0);
        at(27);  lit_a("allred0",      12'h924, 2'd0, 2'd0);
        at(29);  lit_a("green1",       12'h90C, 2'd1, 2'd1);
        at(50);  lit_a("yellow1",      12'h914, 2'd2, 2'd1);
        #2 rst_a = 1'b0;
        #1 lit_a("async_reset",        12'h924, 2'd0, 2'd3);
        release_a();
        at(2);   lit_a("regreen0",     12'h921, 2'd1, 2'd0);
        at(109); lit_a("allred3",      12'h924, 2'd0, 2'd3);
        at(110); lit_a("period_green0", 12'h921, 2'd1, 2'd0);
`else
        at(2);   lit_a("demand_green2", 12'h864, 2'd1, 2'd2);
        pins_b();
        at(30);  lit_a("green_rest2",  12'h864, 2'd1, 2'd2);
        sen_a = 4'b0101;
        at(31);  lit_a("yellow2",      12'h8A4, 2'd2, 2'd2);
        at(35);  lit_a("yellow2_end",  12'h8A4, 2'd2, 2'd2);
        at(36);  lit_a("allred2",      12'h924, 2'd0, 2'd2);
        at(38);  lit_a("wrap_green0",  12'h921, 2'd1, 2'd0);
        #2 rst_a = 1'b0;
        sen_a = 4'b0000;
        #1 lit_a("async_reset",        12'h924, 2'd0, 2'd3);
        release_a();
        at(2);   lit_a("idle_allred",  12'h924, 2'd0, 2'd3);
        at(40);  lit_a("idle_allred40", 12'h924, 2'd0, 2'd3);
        sen_a = 4'b0010;
        at(41);  lit_a("demand_green1", 12'h90C, 2'd1, 2'd1);
`endif
        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

endmodule
